// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared mode encoding and default widths for counter_gen2
package counter_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD   = 2'b00,
        MODE_UP     = 2'b01,
        MODE_DOWN   = 2'b10,
        MODE_BOUNCE = 2'b11
    } mode_e;

    localparam int DEFAULT_WIDTH      = 8;
    localparam int DEFAULT_PRESCALE_W = 8;

endpackage

// File: rtl/counter_prescaler.sv
// rtl/counter_prescaler.sv - enabled-cycle phase counter producing a tick every div+1 cycles
module counter_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE_W = DEFAULT_PRESCALE_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic                  clr,
    input  logic [PRESCALE_W-1:0] div,
    output logic                  tick
);

    localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);

    logic [PRESCALE_W-1:0] phase_q;
    logic [PRESCALE_W-1:0] phase_d;
    logic                  at_top;

    // Using >= lets a shrinking divisor take effect at once: an overshot phase ticks and restarts.
    always_comb begin
        at_top  = (phase_q >= div);
        tick    = ena & at_top;
        phase_d = phase_q;
        if (clr) begin
            phase_d = '0;
        end else if (ena) begin
            phase_d = at_top ? '0 : phase_q + ONE;
        end
    end

    // Phase register; only advances on enabled cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/counter_gen2.sv
// rtl/counter_gen2.sv - up/down/bounce modulo counter with load, match, wrap and sticky ovf (prescaler under COUNTER_PRESCALE_EN)
module counter_gen2
    import counter_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int PRESCALE_W = DEFAULT_PRESCALE_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic [1:0]            mode,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    input  logic [WIDTH-1:0]      limit,
    input  logic [WIDTH-1:0]      cmp_val,
    input  logic [PRESCALE_W-1:0] prescale_div,
    input  logic                  ovf_clr,
    output logic [WIDTH-1:0]      count,
    output logic                  dir,
    output logic                  wrap,
    output logic                  match,
    output logic                  ovf
);

    localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

    logic             tick;
    logic             wr;
    logic [WIDTH-1:0] count_q, count_d;
    logic             dir_q, dir_d;
    logic             wrap_q, wrap_d;
    logic             match_q, match_d;
    logic             ovf_q, ovf_d;

`ifdef COUNTER_PRESCALE_EN
    counter_prescaler #(
        .PRESCALE_W(PRESCALE_W)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .ena  (ena),
        .clr  (load),
        .div  (prescale_div),
        .tick (tick)
    );
`else
    logic unused_prescale_div;
    assign unused_prescale_div = ^prescale_div;
    assign tick = ena;
`endif

    // Next-state: load beats a step; hold mode freezes count and dir even on a tick.
    always_comb begin
        count_d = count_q;
        dir_d   = dir_q;
        wrap_d  = 1'b0;
        wr      = 1'b0;
        if (load) begin
            count_d = load_val;
            wr      = 1'b1;
        end else if (tick) begin
            case (mode_e'(mode))
                MODE_UP: begin
                    dir_d = 1'b1;
                    wr    = 1'b1;
                    if (count_q >= limit) begin
                        count_d = '0;
                        wrap_d  = 1'b1;
                    end else begin
                        count_d = count_q + ONE_W;
                    end
                end
                MODE_DOWN: begin
                    dir_d = 1'b0;
                    wr    = 1'b1;
                    if (count_q == '0) begin
                        count_d = limit;
                        wrap_d  = 1'b1;
                    end else begin
                        count_d = count_q - ONE_W;
                    end
                end
                MODE_BOUNCE: begin
                    wr = 1'b1;
                    if (dir_q) begin
                        if (count_q >= limit) begin
                            dir_d   = 1'b0;
                            count_d = (limit == '0) ? '0 : limit - ONE_W;
                            wrap_d  = 1'b1;
                        end else begin
                            count_d = count_q + ONE_W;
                        end
                    end else begin
                        if (count_q == '0) begin
                            dir_d   = 1'b1;
                            count_d = (limit == '0) ? '0 : ONE_W;
                            wrap_d  = 1'b1;
                        end else begin
                            count_d = count_q - ONE_W;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
        // match only on a written value, so a held count never re-fires it.
        match_d = wr & (count_d == cmp_val);
        // A wrap in the same cycle as a clear leaves the flag set.
        ovf_d   = wrap_d | (ovf_q & ~ovf_clr);
    end

    // State and registered status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            dir_q   <= 1'b1;
            wrap_q  <= 1'b0;
            match_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            dir_q   <= dir_d;
            wrap_q  <= wrap_d;
            match_q <= match_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign dir   = dir_q;
    assign wrap  = wrap_q;
    assign match = match_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_counter_gen2.sv
// tb/tb_counter_gen2.sv - scoreboard bench for counter_gen2 (prescaler checks under COUNTER_PRESCALE_EN)
module tb_counter_gen2;

    localparam int W  = 8;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          ena;
    logic [1:0]    mode;
    logic          load;
    logic [W-1:0]  load_val;
    logic [W-1:0]  limit;
    logic [W-1:0]  cmp_val;
    logic [PW-1:0] prescale_div;
    logic          ovf_clr;
    logic [W-1:0]  count;
    logic          dir;
    logic          wrap;
    logic          match;
    logic          ovf;

    typedef struct packed {
        logic [W-1:0] cnt;
        logic         dir;
        logic         wrap;
        logic         match;
        logic         ovf;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp   = 0;
    int   n_err   = 0;
    int   mon_idx = 0;

    counter_gen2 #(.WIDTH(W), .PRESCALE_W(PW)) dut (
        .clk          (clk),
        .rst          (rst),
        .ena          (ena),
        .mode         (mode),
        .load         (load),
        .load_val     (load_val),
        .limit        (limit),
        .cmp_val      (cmp_val),
        .prescale_div (prescale_div),
        .ovf_clr      (ovf_clr),
        .count        (count),
        .dir          (dir),
        .wrap         (wrap),
        .match        (match),
        .ovf          (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s (step %0d): got %0d, expected %0d", name, idx, act, req);
        end
    endtask

    // Expected response for the edge that follows the current input setup.
    task automatic step(input logic [W-1:0] c, input logic d, input logic w,
                        input logic m, input logic o);
        exp_t e;
        e.cnt   = c;
        e.dir   = d;
        e.wrap  = w;
        e.match = m;
        e.ovf   = o;
        exp_q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    // Monitor: one expected entry per clock, compared away from the rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("count", mon_idx, int'(count), int'(e.cnt));
            chk("dir",   mon_idx, int'(dir),   int'(e.dir));
            chk("wrap",  mon_idx, int'(wrap),  int'(e.wrap));
            chk("match", mon_idx, int'(match), int'(e.match));
            chk("ovf",   mon_idx, int'(ovf),   int'(e.ovf));
            mon_idx++;
        end
    end

    initial begin
        rst          = 1'b1;
        ena          = 1'b0;
        mode         = 2'b00;
        load         = 1'b0;
        load_val     = '0;
        limit        = '0;
        cmp_val      = '0;
        prescale_div = '0;
        ovf_clr      = 1'b0;
        @(negedge clk);
        #1;
        chk("reset_count", -1, int'(count), 0);
        chk("reset_dir",   -1, int'(dir),   1);
        rst = 1'b0;
        step(0, 1, 0, 0, 0);

        // Up, limit 5
        mode    = 2'b01;
        limit   = 5;
        cmp_val = 200;
        ena     = 1'b1;
        step(1, 1, 0, 0, 0);
        step(2, 1, 0, 0, 0);
        step(3, 1, 0, 0, 0);
        step(4, 1, 0, 0, 0);
        step(5, 1, 0, 0, 0);
        step(0, 1, 1, 0, 1);
        step(1, 1, 0, 0, 1);
        step(2, 1, 0, 0, 1);

        // Down, limit 3, load 1 (ovf cleared on the load cycle)
        mode     = 2'b10;
        limit    = 3;
        load     = 1'b1;
        load_val = 1;
        ovf_clr  = 1'b1;
        step(1, 1, 0, 0, 0);
        load    = 1'b0;
        ovf_clr = 1'b0;
        step(0, 0, 0, 0, 0);
        step(3, 0, 1, 0, 1);
        step(2, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);

        // Async reset mid-cycle, then bounce with limit 3
        rst = 1'b1;
        #2;
        chk("async_rst_count", -2, int'(count), 0);
        chk("async_rst_dir",   -2, int'(dir),   1);
        chk("async_rst_ovf",   -2, int'(ovf),   0);
        mode  = 2'b11;
        limit = 3;
        #1;
        rst = 1'b0;
        step(1, 1, 0, 0, 0);
        step(2, 1, 0, 0, 0);
        step(3, 1, 0, 0, 0);
        step(2, 0, 1, 0, 1);
        step(1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(1, 1, 1, 0, 1);

        // Match at 4, up with limit 9
        mode     = 2'b01;
        limit    = 9;
        cmp_val  = 4;
        load     = 1'b1;
        load_val = 0;
        ovf_clr  = 1'b1;
        step(0, 1, 0, 0, 0);
        load    = 1'b0;
        ovf_clr = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            step(W'(i), 1, 0, (i == 4), 0);
        end
        step(0, 1, 1, 0, 1);
        step(1, 1, 0, 0, 1);
        step(2, 1, 0, 0, 1);
        load     = 1'b1;
        load_val = 4;
        step(4, 1, 0, 1, 1);
        load = 1'b0;
        mode = 2'b00;
        step(4, 1, 0, 0, 1);
        step(4, 1, 0, 0, 1);
        step(4, 1, 0, 0, 1);

        // Clear, then wrap with clear held: set wins
        ovf_clr = 1'b1;
        step(4, 1, 0, 0, 0);
        mode  = 2'b01;
        limit = 2;
        step(0, 1, 1, 0, 1);
        ovf_clr = 1'b0;
        // limit 0: every tick wraps
        limit = 0;
        step(0, 1, 1, 0, 1);
        step(0, 1, 1, 0, 1);

        // Down from above limit steps down normally
        mode     = 2'b10;
        limit    = 3;
        load     = 1'b1;
        load_val = 9;
        step(9, 1, 0, 0, 1);
        load = 1'b0;
        step(8, 0, 0, 0, 1);
        step(7, 0, 0, 0, 1);

        // Reset at count 7
        ena = 1'b0;
        rst = 1'b1;
        #2;
        chk("rst7_count", -3, int'(count), 0);
        chk("rst7_dir",   -3, int'(dir),   1);
        chk("rst7_ovf",   -3, int'(ovf),   0);
        mode         = 2'b01;
        limit        = 200;
        cmp_val      = 255;
        prescale_div = 2;
        #1;
        rst = 1'b0;
        ena = 1'b1;
`ifdef COUNTER_PRESCALE_EN
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(2, 1, 0, 0, 0);
        ena = 1'b0;
        step(2, 1, 0, 0, 0);
        step(2, 1, 0, 0, 0);
        ena = 1'b1;
        step(2, 1, 0, 0, 0);
        load     = 1'b1;
        load_val = 10;
        step(10, 1, 0, 0, 0);
        load = 1'b0;
        step(10, 1, 0, 0, 0);
        step(10, 1, 0, 0, 0);
        step(11, 1, 0, 0, 0);
`else
        step(1, 1, 0, 0, 0);
        step(2, 1, 0, 0, 0);
        step(3, 1, 0, 0, 0);
`endif

        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", -4, exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/counter_gen2.md
# counter_gen2

Parametrised successor to the single-purpose TinyTapeout counter. It is a WIDTH-bit programmable counter with up, down and bounce (up/down triangle) modes, a programmable modulo limit, synchronous load, compare-match and wrap pulses, and a sticky overflow flag. An optional clock prescaler is compiled in with a macro. The block sits inside the user project wrapper and is driven from ui_in/uio_in, with count and status routed to uo_out/uio_out.

## Interface
- WIDTH, 8: counter width in bits; legal range 2..16.
- PRESCALE_W, 8: prescaler divisor width in bits.

- clk  in  1  Single clock; all state updates on its rising edge.
- rst  in  1  Asynchronous, active-high reset.
- ena  in  1  Counting enable. When low, count, dir and the prescaler hold; load still acts.
- mode  in  2  Counting mode: 00 hold, 01 up, 10 down, 11 bounce.
- load  in  1  Synchronous load strobe.
- load_val  in  WIDTH  Value loaded into the counter.
- limit  in  WIDTH  Modulo top; the count range is 0..limit.
- cmp_val  in  WIDTH  Compare value.
- prescale_div  in  PRESCALE_W  A step fires every prescale_div+1 enabled cycles.
- ovf_clr  in  1  Clears the sticky ovf flag.
- count  out  WIDTH  Current count.
- dir  out  1  Current direction: 1 = up, 0 = down.
- wrap  out  1  One-cycle pulse when a wrap or turnaround occurs.
- match  out  1  One-cycle pulse when count becomes equal to cmp_val.
- ovf  out  1  Sticky flag; set on any wrap.

## Operation
- tick = ena & prescaler_tick. Without the prescaler macro, tick = ena.
- Priority per cycle: load > tick step > hold.
- load:
  - count <= load_val.
  - The prescaler phase clears to 0.
  - dir is unchanged.
  - wrap is not asserted.
- Up mode (01), on tick:
  - If count >= limit: count <= 0 and wrap fires.
  - Otherwise count <= count+1.
  - dir reads 1.
- Down mode (10), on tick:
  - If count == 0: count <= limit and wrap fires.
  - Otherwise count <= count-1. This applies even when count > limit.
  - dir reads 0.
- Bounce mode (11), on tick:
  - When dir is up and count >= limit: dir <= 0, count <= limit-1 (0 if limit==0), wrap fires.
  - When dir is down and count == 0: dir <= 1, count <= 1 (0 if limit==0), wrap fires.
  - Otherwise count steps in direction dir.
- Hold mode (00): count and dir are frozen. The prescaler keeps running while ena is high.
- Mode changes take effect at the next tick. On entry to 01 or 10, dir is forced to match the mode. On entry to 11, bounce uses the current dir.
- limit == 0: count stays 0, and every tick in modes 01, 10 and 11 produces a wrap.
- match: registered pulse when a load or step writes a value equal to cmp_val. It does not re-fire while the count holds at that value.
- ovf: set by wrap and cleared by ovf_clr. If set and clear occur in the same cycle, set wins.
- All arithmetic is modulo 2^WIDTH. No other overflow path exists beyond the wrap rules above.

## Timing
- Reset values: count=0, dir=1, wrap=0, match=0, ovf=0, prescaler phase=0.
- Reset is asynchronous. Asserting it mid-count clears all state immediately.
- After rst is released, the first step can occur on the first rising edge with tick high.
- Latency: one cycle from a load or tick edge to the new count value.
- wrap and match are registered and become valid in the same cycle as the new count value.
- The prescaler asserts tick on the enabled cycle where phase == prescale_div, then wraps phase to 0.
- With prescale_div=0, a tick fires on every enabled cycle.
- A change to prescale_div takes effect immediately. If phase > prescale_div, the next tick fires and phase resets.

## Configuration
- COUNTER_PRESCALE_EN:
  - Defined: the prescaler is instantiated and tick follows the rule above.
  - Undefined: tick = ena, the prescale_div port remains but is ignored, and no prescaler flops are synthesised.

## Structure
- Shared package counter_pkg holds:
  - the mode enum: MODE_HOLD, MODE_UP, MODE_DOWN, MODE_BOUNCE;
  - the default-width constants.
- Sub-module counter_prescaler contains the phase counter and tick generation. It is instantiated only under COUNTER_PRESCALE_EN.

## Test plan
- Mode up, limit=5, prescale_div=0, ena=1 for 8 cycles -> count 1,2,3,4,5,0,1,2; wrap high on the cycle count=0; ovf=1.
- Mode down, limit=3, load load_val=1, then 4 ticks -> count 0,3,2,1; wrap on count=3.
- Mode bounce, limit=3, from reset -> count 1,2,3,2,1,0,1; dir flips at 3 and at 0; wrap at both turnarounds.
- cmp_val=4, mode up, limit=9 -> match pulses exactly once per pass. Load 4 while counting -> match pulses; hold in mode 00 -> no repeat.
- With COUNTER_PRESCALE_EN and prescale_div=2 -> count increments every 3rd cycle. Drop ena for 2 cycles -> count and phase hold. Assert load -> phase resets.
- Assert rst mid-count at count=7 -> count=0, dir=1, ovf=0 immediately without a clock edge. Same-cycle wrap and ovf_clr -> ovf remains 1.
